// File: rtl/fifo_sched_pkg.sv
// Shared constants, channel state type and mode helper for the RLWE input-FIFO slot scheduler.
package fifo_sched_pkg;

   // Requester bit positions: write channel {acc, DMA}, read channel {DMA, iNTT}
   localparam int REQ_DMA    = 0;
   localparam int REQ_ACC    = 1;
   localparam int REQ_INTT   = 0;
   localparam int REQ_DMA_RD = 1;

   localparam logic MODE_BOOT = 1'b0;
   localparam logic MODE_SUBS = 1'b1;

   typedef enum logic {
      CH_IDLE  = 1'b0,
      CH_GRANT = 1'b1
   } ch_state_t;

   // In RLWESUBS/RGSW mode only requester 0 (DMA write, iNTT read) may be served
   function automatic logic [1:0] mode_mask(input logic mode, input logic [1:0] req);
      logic [1:0] masked;
      if (mode == MODE_SUBS) begin
         masked = req & 2'b01;
      end else begin
         masked = req;
      end
      return masked;
   endfunction

endpackage

// File: rtl/rlwe_fifo_slot_scheduler_if.sv
// Handshake/status bundle between the slot scheduler and its clients (top control, DMA, iNTT, acc).
interface rlwe_fifo_slot_scheduler_if #(
   parameter int PW = 2
);
   logic          mode_sel;
   logic          mode_act;
   logic [1:0]    wr_req;
   logic [1:0]    wr_done;
   logic [1:0]    wr_gnt;
   logic [PW-1:0] wr_slot;
   logic [1:0]    rd_req;
   logic [1:0]    rd_done;
   logic [1:0]    rd_gnt;
   logic [PW-1:0] rd_slot;
   logic [PW:0]   count;
   logic          empty;
   logic          full;
   logic          busy;
   logic          err;

   modport master (
      output mode_sel, wr_req, wr_done, rd_req, rd_done,
      input  mode_act, wr_gnt, wr_slot, rd_gnt, rd_slot, count, empty, full, busy, err
   );

   modport slave (
      input  mode_sel, wr_req, wr_done, rd_req, rd_done,
      output mode_act, wr_gnt, wr_slot, rd_gnt, rd_slot, count, empty, full, busy, err
   );
endinterface

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; the last tie winner loses the next tie.
module rr_arb2 #(
   parameter int FIRST_WIN = 0
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       en,
   input  logic [1:0] req,
   output logic [1:0] gnt
);

   // Seed the history so FIRST_WIN takes the first tie after reset
   localparam logic LAST_RST = (FIRST_WIN == 0) ? 1'b1 : 1'b0;

   logic last_q;
   logic last_d;

   // Combinational grant selection
   always_comb begin
      gnt = 2'b00;
      case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = last_q ? 2'b01 : 2'b10;
         default: gnt = 2'b00;
      endcase
   end

   // History only moves on a contested grant that is actually issued
   always_comb begin
      last_d = last_q;
      if (en && (req == 2'b11)) begin
         last_d = gnt[1];
      end else begin
         last_d = last_q;
      end
   end

   // Last-winner register
   always_ff @(posedge clk) begin
      if (!rstn) begin
         last_q <= LAST_RST;
      end else begin
         last_q <= last_d;
      end
   end

endmodule

// File: rtl/rlwe_fifo_slot_scheduler.sv
// Slot scheduler for the RLWE poly a/b FIFO pair: one write and one read grant,
// shared slot pointers, occupancy flags, deferred mode switch and sticky protocol error.
module rlwe_fifo_slot_scheduler
   import fifo_sched_pkg::*;
#(
   parameter int POINTER_WIDTH = 2
) (
   input  logic                         clk,
   input  logic                         rstn,
   rlwe_fifo_slot_scheduler_if.slave    bus
);

   localparam int          PW           = POINTER_WIDTH;
   localparam int          BUFFER_DEPTH = 2 ** PW;
   localparam logic [PW:0] DEPTH_V      = (PW + 1)'(BUFFER_DEPTH);
   localparam logic [PW:0] ZERO_V       = '0;
   localparam logic [PW:0] ONE_V        = (PW + 1)'(1);

   ch_state_t   wr_state_q, wr_state_d;
   ch_state_t   rd_state_q, rd_state_d;
   logic [1:0]  wr_gnt_q, wr_gnt_d;
   logic [1:0]  rd_gnt_q, rd_gnt_d;
   logic [PW:0] wr_ptr_q, wr_ptr_d;
   logic [PW:0] rd_ptr_q, rd_ptr_d;
   logic [PW:0] count_q, count_d;
   logic        empty_q, empty_d;
   logic        full_q, full_d;
   logic        busy_q, busy_d;
   logic        err_q, err_d;
   logic        mode_act_q, mode_act_d;

   logic [1:0]  wr_elig, rd_elig;
   logic [1:0]  wr_arb_gnt, rd_arb_gnt;
   logic        wr_issue, rd_issue;
   logic        wr_done_ok, rd_done_ok;
   logic        wr_done_bad, rd_done_bad;

   // Eligibility, issue decisions and done qualification from registered state only
   always_comb begin
      wr_elig     = mode_mask(mode_act_q, bus.wr_req);
      rd_elig     = mode_mask(mode_act_q, bus.rd_req);
      wr_issue    = (wr_state_q == CH_IDLE) && !full_q  && (wr_elig != 2'b00);
      rd_issue    = (rd_state_q == CH_IDLE) && !empty_q && (rd_elig != 2'b00);
      wr_done_ok  = (wr_state_q == CH_GRANT) && (bus.wr_done == wr_gnt_q);
      rd_done_ok  = (rd_state_q == CH_GRANT) && (bus.rd_done == rd_gnt_q);
      wr_done_bad = (bus.wr_done != 2'b00) && !wr_done_ok;
      rd_done_bad = (bus.rd_done != 2'b00) && !rd_done_ok;
   end

   rr_arb2 #(.FIRST_WIN(REQ_ACC)) u_wr_arb (
      .clk  (clk),
      .rstn (rstn),
      .en   (wr_issue),
      .req  (wr_elig),
      .gnt  (wr_arb_gnt)
   );

   rr_arb2 #(.FIRST_WIN(REQ_INTT)) u_rd_arb (
      .clk  (clk),
      .rstn (rstn),
      .en   (rd_issue),
      .req  (rd_elig),
      .gnt  (rd_arb_gnt)
   );

   // Write channel FSM
   always_comb begin
      wr_state_d = wr_state_q;
      wr_gnt_d   = wr_gnt_q;
      case (wr_state_q)
         CH_IDLE: begin
            if (wr_issue) begin
               wr_state_d = CH_GRANT;
               wr_gnt_d   = wr_arb_gnt;
            end else begin
               wr_state_d = CH_IDLE;
               wr_gnt_d   = 2'b00;
            end
         end
         CH_GRANT: begin
            if (wr_done_ok) begin
               wr_state_d = CH_IDLE;
               wr_gnt_d   = 2'b00;
            end else begin
               wr_state_d = CH_GRANT;
               wr_gnt_d   = wr_gnt_q;
            end
         end
         default: begin
            wr_state_d = CH_IDLE;
            wr_gnt_d   = 2'b00;
         end
      endcase
   end

   // Read channel FSM
   always_comb begin
      rd_state_d = rd_state_q;
      rd_gnt_d   = rd_gnt_q;
      case (rd_state_q)
         CH_IDLE: begin
            if (rd_issue) begin
               rd_state_d = CH_GRANT;
               rd_gnt_d   = rd_arb_gnt;
            end else begin
               rd_state_d = CH_IDLE;
               rd_gnt_d   = 2'b00;
            end
         end
         CH_GRANT: begin
            if (rd_done_ok) begin
               rd_state_d = CH_IDLE;
               rd_gnt_d   = 2'b00;
            end else begin
               rd_state_d = CH_GRANT;
               rd_gnt_d   = rd_gnt_q;
            end
         end
         default: begin
            rd_state_d = CH_IDLE;
            rd_gnt_d   = 2'b00;
         end
      endcase
   end

   // Pointers, occupancy flags, error and mode hand-over
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      mode_act_d = mode_act_q;
      if (wr_done_ok) begin
         wr_ptr_d = wr_ptr_q + ONE_V;
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (rd_done_ok) begin
         rd_ptr_d = rd_ptr_q + ONE_V;
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      count_d = wr_ptr_d - rd_ptr_d;
      empty_d = (count_d == ZERO_V);
      full_d  = (count_d == DEPTH_V);
      busy_d  = (wr_gnt_d != 2'b00) || (rd_gnt_d != 2'b00);
      err_d   = err_q || wr_done_bad || rd_done_bad;
      // A new mode only lands on a fully quiet cycle so no grant sees a mode flip mid-flight
      if ((wr_state_q == CH_IDLE) && (rd_state_q == CH_IDLE) && !wr_issue && !rd_issue) begin
         mode_act_d = bus.mode_sel;
      end else begin
         mode_act_d = mode_act_q;
      end
   end

   // State registers
   always_ff @(posedge clk) begin
      if (!rstn) begin
         wr_state_q <= CH_IDLE;
         rd_state_q <= CH_IDLE;
         wr_gnt_q   <= 2'b00;
         rd_gnt_q   <= 2'b00;
         wr_ptr_q   <= ZERO_V;
         rd_ptr_q   <= ZERO_V;
         count_q    <= ZERO_V;
         empty_q    <= 1'b1;
         full_q     <= 1'b0;
         busy_q     <= 1'b0;
         err_q      <= 1'b0;
         mode_act_q <= bus.mode_sel;
      end else begin
         wr_state_q <= wr_state_d;
         rd_state_q <= rd_state_d;
         wr_gnt_q   <= wr_gnt_d;
         rd_gnt_q   <= rd_gnt_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         empty_q    <= empty_d;
         full_q     <= full_d;
         busy_q     <= busy_d;
         err_q      <= err_d;
         mode_act_q <= mode_act_d;
      end
   end

   assign bus.mode_act = mode_act_q;
   assign bus.wr_gnt   = wr_gnt_q;
   assign bus.rd_gnt   = rd_gnt_q;
   assign bus.wr_slot  = wr_ptr_q[PW-1:0];
   assign bus.rd_slot  = rd_ptr_q[PW-1:0];
   assign bus.count    = count_q;
   assign bus.empty    = empty_q;
   assign bus.full     = full_q;
   assign bus.busy     = busy_q;
   assign bus.err      = err_q;

endmodule

// File: tb/tb_rlwe_fifo_slot_scheduler.sv
// Directed bench for rlwe_fifo_slot_scheduler: an occupancy/owner model checked every cycle,
// plus hand-computed literal expectations at the interesting points.
module tb_rlwe_fifo_slot_scheduler;
   import fifo_sched_pkg::*;

   logic clk = 1'b0;
   logic rstn;
   always #5 clk = ~clk;

   rlwe_fifo_slot_scheduler_if #(.PW(2)) bus ();

   rlwe_fifo_slot_scheduler #(.POINTER_WIDTH(2)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   int vectors     = 0;
   int miscompares = 0;

   // Model: who owns each channel (0 = nobody, else one-hot), slot numbers, occupancy
   int m_occ, m_wslot, m_rslot, m_wg, m_rg, m_wlast, m_rlast;
   bit m_err, m_mode;
   bit m_valid = 1'b0;

   // Winner of a request pair: tie goes to whoever did not win the previous tie
   function automatic int pick(input logic [1:0] elig, input int last_tie);
      if (elig == 2'b11) return (last_tie == 1) ? 0 : 1;
      else if (elig[1])  return 1;
      else               return 0;
   endfunction

   always @(posedge clk) begin
      int  wq, rq, w, r;
      bit  wdone, rdone, wiss, riss;
      logic [1:0] we, re;
      if (!rstn) begin
         m_occ = 0; m_wslot = 0; m_rslot = 0; m_wg = 0; m_rg = 0;
         m_wlast = 0;  // acc takes the first write tie
         m_rlast = 1;  // iNTT takes the first read tie
         m_err = 1'b0; m_mode = bus.mode_sel; m_valid = 1'b1;
      end else begin
         wdone = 1'b0; rdone = 1'b0; wiss = 1'b0; riss = 1'b0;
         wq = m_wg; rq = m_rg;
         if (bus.wr_done != 2'b00) begin
            if (m_wg != 0 && int'(bus.wr_done) == m_wg) wdone = 1'b1;
            else m_err = 1'b1;
         end
         if (bus.rd_done != 2'b00) begin
            if (m_rg != 0 && int'(bus.rd_done) == m_rg) rdone = 1'b1;
            else m_err = 1'b1;
         end
         we = m_mode ? (bus.wr_req & 2'b01) : bus.wr_req;
         re = m_mode ? (bus.rd_req & 2'b01) : bus.rd_req;
         if (m_wg == 0 && we != 2'b00 && m_occ < 4) begin
            w = pick(we, m_wlast);
            if (we == 2'b11) m_wlast = w;
            wq = 1 << w; wiss = 1'b1;
         end
         if (m_rg == 0 && re != 2'b00 && m_occ > 0) begin
            r = pick(re, m_rlast);
            if (re == 2'b11) m_rlast = r;
            rq = 1 << r; riss = 1'b1;
         end
         if (m_wg == 0 && m_rg == 0 && !wiss && !riss) m_mode = bus.mode_sel;
         if (wdone) begin wq = 0; m_wslot = (m_wslot + 1) % 4; m_occ = m_occ + 1; end
         if (rdone) begin rq = 0; m_rslot = (m_rslot + 1) % 4; m_occ = m_occ - 1; end
         m_wg = wq; m_rg = rq;
      end
   end

   always @(negedge clk) begin
      logic [1:0] e_wg, e_rg;
      logic [2:0] e_cnt;
      logic       e_busy;
      if (m_valid) begin
         e_wg   = 2'(m_wg);
         e_rg   = 2'(m_rg);
         e_cnt  = 3'(m_occ);
         e_busy = (m_wg != 0) || (m_rg != 0);
         vectors++;
         if (bus.wr_gnt !== e_wg || bus.rd_gnt !== e_rg || bus.wr_slot !== 2'(m_wslot) ||
             bus.rd_slot !== 2'(m_rslot) || bus.count !== e_cnt || bus.empty !== (m_occ == 0) ||
             bus.full !== (m_occ == 4) || bus.busy !== e_busy || bus.err !== m_err ||
             bus.mode_act !== m_mode) begin
            miscompares++;
            $display("FAIL model_cycle t=%0t got wg=%b rg=%b ws=%0d rs=%0d cnt=%0d e=%b f=%b b=%b err=%b m=%b want wg=%b rg=%b ws=%0d rs=%0d cnt=%0d e=%b f=%b b=%b err=%b m=%b",
                     $time, bus.wr_gnt, bus.rd_gnt, bus.wr_slot, bus.rd_slot, bus.count, bus.empty,
                     bus.full, bus.busy, bus.err, bus.mode_act, e_wg, e_rg, m_wslot, m_rslot,
                     m_occ, (m_occ == 0), (m_occ == 4), e_busy, m_err, m_mode);
         end
      end
   end

   task automatic chk(input string name, input int got, input int exp);
      vectors++;
      if (got != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_wr_gnt(input int lim);
      int i = 0;
      @(negedge clk);
      while (bus.wr_gnt == 2'b00 && i < lim) begin
         @(negedge clk);
         i++;
      end
   endtask

   task automatic wait_rd_gnt(input int lim);
      int i = 0;
      @(negedge clk);
      while (bus.rd_gnt == 2'b00 && i < lim) begin
         @(negedge clk);
         i++;
      end
   endtask

   task automatic write_slot(input logic [1:0] req, input logic [1:0] gnt, input int slot, input int cnt);
      bus.wr_req = req;
      wait_wr_gnt(20);
      chk("wr_gnt", int'(bus.wr_gnt), int'(gnt));
      chk("wr_slot", int'(bus.wr_slot), slot);
      bus.wr_req = 2'b00;
      tick(5);
      bus.wr_done = gnt;
      tick(1);
      bus.wr_done = 2'b00;
      chk("wr_count", int'(bus.count), cnt);
   endtask

   task automatic read_slot(input logic [1:0] req, input logic [1:0] gnt, input int slot, input int cnt);
      bus.rd_req = req;
      wait_rd_gnt(20);
      chk("rd_gnt", int'(bus.rd_gnt), int'(gnt));
      chk("rd_slot", int'(bus.rd_slot), slot);
      bus.rd_req = 2'b00;
      tick(2);
      bus.rd_done = gnt;
      tick(1);
      bus.rd_done = 2'b00;
      chk("rd_count", int'(bus.count), cnt);
   endtask

   initial begin
      rstn = 1'b0;
      bus.mode_sel = MODE_SUBS;
      bus.wr_req = 2'b00; bus.wr_done = 2'b00;
      bus.rd_req = 2'b00; bus.rd_done = 2'b00;
      tick(2);
      chk("rst_count", int'(bus.count), 0);
      chk("rst_empty", int'(bus.empty), 1);
      chk("rst_full", int'(bus.full), 0);
      chk("rst_busy", int'(bus.busy), 0);
      chk("rst_err", int'(bus.err), 0);
      chk("rst_mode", int'(bus.mode_act), 1);
      chk("rst_gnts", int'({bus.wr_gnt, bus.rd_gnt}), 0);
      rstn = 1'b1;

      // Mode 1: fill all four slots through DMA
      for (int k = 0; k < 4; k++) write_slot(2'b01, 2'b01, k, k + 1);
      chk("full_at_4", int'(bus.full), 1);
      bus.wr_req = 2'b01; tick(6);
      chk("no_wr_when_full", int'(bus.wr_gnt), 0);
      bus.wr_req = 2'b00;

      // Mode 1: DMA read-out is never served; iNTT drains two slots
      bus.rd_req = 2'b10; tick(6);
      chk("no_dma_rd_mode1", int'(bus.rd_gnt), 0);
      bus.rd_req = 2'b00;
      read_slot(2'b01, 2'b01, 0, 3);
      read_slot(2'b01, 2'b01, 1, 2);

      // Mode 0: both readers held, grants alternate iNTT then DMA, then stop at empty
      bus.mode_sel = MODE_BOOT; tick(2);
      chk("mode_boot", int'(bus.mode_act), 0);
      bus.rd_req = 2'b11;
      wait_rd_gnt(20);
      chk("alt_first", int'(bus.rd_gnt), 1);
      chk("alt_first_slot", int'(bus.rd_slot), 2);
      tick(2); bus.rd_done = 2'b01; tick(1); bus.rd_done = 2'b00;
      wait_rd_gnt(20);
      chk("alt_second", int'(bus.rd_gnt), 2);
      chk("alt_second_slot", int'(bus.rd_slot), 3);
      tick(2); bus.rd_done = 2'b10; tick(1); bus.rd_done = 2'b00;
      tick(5);
      chk("no_rd_when_empty", int'(bus.rd_gnt), 0);
      chk("empty_after_drain", int'(bus.empty), 1);
      bus.rd_req = 2'b00;

      // Mode 0 write tie: acc wins first
      write_slot(2'b11, 2'b10, 0, 1);

      // count=1, simultaneous done on both channels
      bus.wr_req = 2'b01; bus.rd_req = 2'b01;
      wait_wr_gnt(20);
      chk("both_wr_gnt", int'(bus.wr_gnt), 1);
      chk("both_rd_gnt", int'(bus.rd_gnt), 1);
      chk("both_wr_slot", int'(bus.wr_slot), 1);
      chk("both_rd_slot", int'(bus.rd_slot), 0);
      bus.wr_req = 2'b00; bus.rd_req = 2'b00;
      tick(2);
      bus.wr_done = 2'b01; bus.rd_done = 2'b01; tick(1);
      bus.wr_done = 2'b00; bus.rd_done = 2'b00;
      chk("sim_count", int'(bus.count), 1);
      chk("sim_wr_slot", int'(bus.wr_slot), 2);
      chk("sim_rd_slot", int'(bus.rd_slot), 1);

      // Mode change requested mid-grant is deferred until both channels are quiet
      bus.wr_req = 2'b01;
      wait_wr_gnt(20);
      chk("defer_wr_slot", int'(bus.wr_slot), 2);
      bus.mode_sel = MODE_SUBS; tick(3);
      chk("defer_mode_busy", int'(bus.mode_act), 0);
      bus.wr_req = 2'b00;
      bus.wr_done = 2'b01; tick(1); bus.wr_done = 2'b00;
      chk("defer_mode_done", int'(bus.mode_act), 0);
      chk("defer_count", int'(bus.count), 2);
      tick(1);
      chk("defer_mode_applied", int'(bus.mode_act), 1);

      // Wrong-index done while iNTT is granted
      bus.rd_req = 2'b01;
      wait_rd_gnt(20);
      chk("err_rd_slot", int'(bus.rd_slot), 1);
      bus.rd_req = 2'b00;
      bus.rd_done = 2'b10; tick(1); bus.rd_done = 2'b00;
      chk("err_set", int'(bus.err), 1);
      chk("err_count", int'(bus.count), 2);
      chk("err_rd_slot_kept", int'(bus.rd_slot), 1);
      chk("err_gnt_kept", int'(bus.rd_gnt), 1);

      // Reset while the read grant is still held
      bus.mode_sel = MODE_BOOT;
      rstn = 1'b0; tick(1);
      chk("rst2_rd_gnt", int'(bus.rd_gnt), 0);
      chk("rst2_count", int'(bus.count), 0);
      chk("rst2_err", int'(bus.err), 0);
      chk("rst2_mode", int'(bus.mode_act), 0);
      chk("rst2_empty", int'(bus.empty), 1);
      chk("rst2_rd_slot", int'(bus.rd_slot), 0);
      rstn = 1'b1;

      // Done with no grant outstanding
      tick(1);
      bus.wr_done = 2'b01; tick(1); bus.wr_done = 2'b00;
      chk("err_no_gnt", int'(bus.err), 1);
      chk("err_no_gnt_count", int'(bus.count), 0);
      tick(2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
